tpuv2: RTL and testbench

Parametrised memory-mapped matrix-multiply accelerator, the next generation of the TPU top level. It decodes a word-addressed register/command space and stages wide A/B rows from narrower bus words. It drives the existing `systolic_array`, `memA` and `memB` submodules through a timed compute window, and exposes busy/done status both as ports and as a readable register. It sits directly on the host bus, in place of the previous top.

---
 rtl/tpuv2.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_tpuv2.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpuv2.sv
// tpuv2: memory-mapped matrix-multiply accelerator top level.
// Host accesses are decoded from addr[15:12] (command) and addr[11:3]
// (word index). Wide A/B rows are assembled from bus words in staging
// buffers and committed to memA/memB on the last part. A start command
// opens a fixed 3*DIM-1 cycle compute window on the systolic array.
// Handshake: there is no valid/ready pair. A write is qualified by r_w=1
// in the cycle it is presented and completes at that clock edge. A read
// (r_w=0) returns dataOut combinationally in the same cycle.

// memA: DIM rows of DIM signed elements, written one full row at a time.
module memA #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           WrEn,
    input  logic [$clog2(DIM)-1:0]         Arow,
    input  logic [DIM*BITS_AB-1:0]         Ain,
    output logic [DIM*DIM*BITS_AB-1:0]     Amat
);
    logic [DIM*BITS_AB-1:0] rows [DIM];

    // Row store: a commit replaces the addressed row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) rows[r] <= '0;
        end else if (WrEn) begin
            rows[Arow] <= Ain;
        end
    end

    // Flatten the rows so the array sees the whole matrix.
    always_comb begin
        for (int r = 0; r < DIM; r++) Amat[r*DIM*BITS_AB +: DIM*BITS_AB] = rows[r];
    end
endmodule

// memB: like memA, but rows are filled in arrival order by a wrapping
// write pointer, since the host supplies no B row address.
module memB #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           WrEn,
    input  logic [DIM*BITS_AB-1:0]         Bin,
    output logic [DIM*DIM*BITS_AB-1:0]     Bmat
);
    logic [DIM*BITS_AB-1:0] rows [DIM];
    logic [$clog2(DIM)-1:0] wptr;

    // Row store plus write pointer; DIM is a power of two so the pointer wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) rows[r] <= '0;
            wptr <= '0;
        end else if (WrEn) begin
            rows[wptr] <= Bin;
            wptr       <= wptr + 1'b1;
        end
    end

    // Flatten the rows so the array sees the whole matrix.
    always_comb begin
        for (int r = 0; r < DIM; r++) Bmat[r*DIM*BITS_AB +: DIM*BITS_AB] = rows[r];
    end
endmodule

// systolic_array: output-stationary DIM x DIM array. PE(i,j) sees operand
// pair k at window cycle i+j+k, which is the skewed wavefront of a
// classic systolic feed. Accumulators double as the host-visible C memory.
module systolic_array #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int CNTW    = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [CNTW-1:0]                cnt,
    input  logic [DIM*DIM*BITS_AB-1:0]     Amat,
    input  logic [DIM*DIM*BITS_AB-1:0]     Bmat,
    input  logic                           CWrEn,
    input  logic [$clog2(DIM)-1:0]         Crow,
    input  logic [DIM*BITS_C-1:0]          Cin,
    output logic [DIM*BITS_C-1:0]          Cout
);
    logic [DIM*BITS_C-1:0] acc  [DIM];
    logic [BITS_C-1:0]     prod [DIM][DIM];

    function automatic logic [BITS_C-1:0] sext(input logic [BITS_AB-1:0] x);
        return {{(BITS_C-BITS_AB){x[BITS_AB-1]}}, x};
    endfunction

    // Per-PE product for the operand pair whose wavefront reaches it this cycle.
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                prod[i][j] = '0;
                for (int k = 0; k < DIM; k++) begin
                    if (int'(cnt) == i + j + k) begin
                        prod[i][j] = sext(Amat[(i*DIM+k)*BITS_AB +: BITS_AB])
                                   * sext(Bmat[(k*DIM+j)*BITS_AB +: BITS_AB]);
                    end
                end
            end
        end
    end

    // Accumulators: host row write when idle, multiply-accumulate when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) acc[i] <= '0;
        end else if (CWrEn) begin
            acc[Crow] <= Cin;
        end else if (en) begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    acc[i][j*BITS_C +: BITS_C] <= acc[i][j*BITS_C +: BITS_C] + prod[i][j];
                end
            end
        end
    end

    assign Cout = acc[Crow];
endmodule

module tpuv2 #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r_w,
    input  logic [ADDRW-1:0]  addr,
    input  logic [DATAW-1:0]  dataIn,
    output logic [DATAW-1:0]  dataOut,
    output logic              busy,
    output logic              done
);
    localparam int WA   = DIM*BITS_AB/DATAW;
    localparam int WC   = DIM*BITS_C/DATAW;
    localparam int RW   = $clog2(DIM);
    localparam int CNTW = $clog2(3*DIM);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(3*DIM-2);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic            done_q, done_nxt;

    logic [3:0] cmd;
    logic [8:0] w, ab_row, ab_part, c_row, c_chunk;
    logic       ab_row_ok, c_row_ok, ab_last, wr_ok;
    logic       a_cmd, b_cmd, c_wr, start, status_clr;
    logic       unused_addr;

    logic [DATAW-1:0]           a_stage [WA];
    logic [DATAW-1:0]           b_stage [WA];
    logic [DIM*BITS_AB-1:0]     ain, bin;
    logic [DIM*DIM*BITS_AB-1:0] amat, bmat;
    logic [DIM*BITS_C-1:0]      cin, cout;

    // Only addr[15:3] carries meaning; the remaining bits are don't-care.
    assign unused_addr = ^addr;

    assign cmd       = addr[15:12];
    assign w         = addr[11:3];
    assign ab_row    = w / 9'(WA);
    assign ab_part   = w % 9'(WA);
    assign c_row     = w / 9'(WC);
    assign c_chunk   = w % 9'(WC);
    assign ab_row_ok = ab_row < 9'(DIM);
    assign c_row_ok  = c_row < 9'(DIM);
    assign ab_last   = ab_part == 9'(WA-1);

    // Data-path writes and starts are locked out for the whole window.
    assign wr_ok      = r_w && !busy;
    assign a_cmd      = wr_ok && cmd == 4'd1 && ab_row_ok;
    assign b_cmd      = wr_ok && cmd == 4'd2 && ab_row_ok;
    assign c_wr       = wr_ok && cmd == 4'd3 && c_row_ok;
    assign start      = wr_ok && cmd == 4'd4;
    assign status_clr = r_w && cmd == 4'd5 && dataIn[1];

    // Staging slots below the top part; the top slot is never loaded because
    // the last part goes straight from dataIn into the committed row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < WA; p++) begin
                a_stage[p] <= '0;
                b_stage[p] <= '0;
            end
        end else begin
            for (int p = 0; p < WA-1; p++) begin
                if (a_cmd && ab_part == 9'(p)) a_stage[p] <= dataIn;
                if (b_cmd && ab_part == 9'(p)) b_stage[p] <= dataIn;
            end
        end
    end

    // Full row = staged lower parts with the current word on top.
    always_comb begin
        for (int p = 0; p < WA; p++) begin
            ain[p*DATAW +: DATAW] = (p == WA-1) ? dataIn : a_stage[p];
            bin[p*DATAW +: DATAW] = (p == WA-1) ? dataIn : b_stage[p];
        end
    end

    // C write merges the new chunk into the live row (read-modify-write).
    always_comb begin
        for (int ch = 0; ch < WC; ch++) begin
            cin[ch*DATAW +: DATAW] = (c_chunk == 9'(ch)) ? dataIn : cout[ch*DATAW +: DATAW];
        end
    end

    // Compute-window state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    // Window sequencing; completion is assigned last so it beats a clear.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = done_q;
        if (status_clr) done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == RUN);
    assign done = done_q;

    // Read mux: C chunk or status; everything else reads as zero.
    always_comb begin
        dataOut = '0;
        if (!r_w) begin
            if (cmd == 4'd3 && c_row_ok) begin
                for (int ch = 0; ch < WC; ch++) begin
                    if (c_chunk == 9'(ch)) dataOut = cout[ch*DATAW +: DATAW];
                end
            end else if (cmd == 4'd5) begin
                dataOut[1:0] = {done_q, busy};
            end
        end
    end

    memA #(.BITS_AB(BITS_AB), .DIM(DIM)) u_mema (
        .clk   (clk),
        .rst_n (rst_n),
        .WrEn  (a_cmd && ab_last),
        .Arow  (ab_row[RW-1:0]),
        .Ain   (ain),
        .Amat  (amat)
    );

    memB #(.BITS_AB(BITS_AB), .DIM(DIM)) u_memb (
        .clk   (clk),
        .rst_n (rst_n),
        .WrEn  (b_cmd && ab_last),
        .Bin   (bin),
        .Bmat  (bmat)
    );

    systolic_array #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM), .CNTW(CNTW)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy),
        .cnt   (cnt),
        .Amat  (amat),
        .Bmat  (bmat),
        .CWrEn (c_wr),
        .Crow  (c_row[RW-1:0]),
        .Cin   (cin),
        .Cout  (cout)
    );
endmodule

// File: tb/tb_tpuv2.sv
// Bench for tpuv2: one DIM=8 and one DIM=16 instance on a shared clock,
// table-driven vectors, timed corner sequences and a random run against
// a matrix-level reference model.
module tb_tpuv2;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        r_w   [2];
    logic [15:0] addr  [2];
    logic [63:0] din   [2];
    logic [63:0] dout  [2];
    logic        busy  [2];
    logic        done  [2];

    tpuv2 #(.DIM(8)) dut8 (
        .clk(clk), .rst_n(rst_n[0]), .r_w(r_w[0]), .addr(addr[0]),
        .dataIn(din[0]), .dataOut(dout[0]), .busy(busy[0]), .done(done[0])
    );

    tpuv2 #(.DIM(16)) dut16 (
        .clk(clk), .rst_n(rst_n[1]), .r_w(r_w[1]), .addr(addr[1]),
        .dataIn(din[1]), .dataOut(dout[1]), .busy(busy[1]), .done(done[1])
    );

    int wren_a16 = 0;
    always @(posedge clk) if (dut16.u_mema.WrEn) wren_a16++;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // ---------------- reference model ----------------
    int          ma [2][16][16];
    int          mb [2][16][16];
    int          mc [2][16][16];
    logic [63:0] sa [2][2];
    logic [63:0] sb [2][2];
    int          bp [2];
    logic        mdone [2];

    function automatic int dimof(input int d);
        return (d == 0) ? 8 : 16;
    endfunction

    function automatic void model_reset(input int d);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                ma[d][i][j] = 0; mb[d][i][j] = 0; mc[d][i][j] = 0;
            end
        for (int p = 0; p < 2; p++) begin sa[d][p] = '0; sb[d][p] = '0; end
        bp[d] = 0;
        mdone[d] = 1'b0;
    endfunction

    function automatic void model_write(input int d, input int cmd, input int w, input logic [63:0] v);
        int dm = dimof(d);
        int wa = dm / 8;
        int wc = dm / 4;
        int row, part;
        logic [127:0] rv;
        logic [7:0] b8;
        if (cmd == 1 || cmd == 2) begin
            row = w / wa; part = w % wa;
            if (row < dm) begin
                if (part != wa - 1) begin
                    if (cmd == 1) sa[d][part] = v; else sb[d][part] = v;
                end else begin
                    rv = '0;
                    for (int p = 0; p < wa; p++)
                        rv[p*64 +: 64] = (p == wa - 1) ? v : ((cmd == 1) ? sa[d][p] : sb[d][p]);
                    for (int k = 0; k < dm; k++) begin
                        b8 = rv[k*8 +: 8];
                        if (cmd == 1) ma[d][row][k] = int'($signed(b8));
                        else          mb[d][bp[d]][k] = int'($signed(b8));
                    end
                    if (cmd == 2) bp[d] = (bp[d] + 1) % dm;
                end
            end
        end else if (cmd == 3) begin
            row = w / wc; part = w % wc;
            if (row < dm)
                for (int l = 0; l < 4; l++) mc[d][row][part*4 + l] = int'(v[l*16 +: 16]);
        end else if (cmd == 5 && v[1]) begin
            mdone[d] = 1'b0;
        end
    endfunction

    // Status is modelled for the idle case only; reads happen between windows.
    function automatic logic [63:0] model_read(input int d, input int cmd, input int w);
        int dm = dimof(d);
        int wc = dm / 4;
        logic [63:0] v = '0;
        if (cmd == 3 && (w / wc) < dm) begin
            for (int l = 0; l < 4; l++) v[l*16 +: 16] = 16'(mc[d][w / wc][(w % wc)*4 + l]);
        end else if (cmd == 5) begin
            v[1] = mdone[d];
        end
        return v;
    endfunction

    // C += A x B, wrapped to 16 bits.
    function automatic void model_compute(input int d);
        int dm = dimof(d);
        int s;
        for (int i = 0; i < dm; i++)
            for (int j = 0; j < dm; j++) begin
                s = mc[d][i][j];
                for (int k = 0; k < dm; k++) s += ma[d][i][k] * mb[d][k][j];
                mc[d][i][j] = s & 32'hFFFF;
            end
    endfunction

    function automatic logic [63:0] lanes(input logic [63:0] src, input int off);
        logic [63:0] r = '0;
        logic [7:0] b;
        for (int l = 0; l < 4; l++) begin
            b = src[(off + l)*8 +: 8];
            r[l*16 +: 16] = {{8{b[7]}}, b};
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    function automatic logic [15:0] mk(input int cmd, input int w);
        return 16'((cmd << 12) | (w << 3));
    endfunction

    // Called just after a rising edge; the write is sampled at the next edge.
    task automatic wr(input int d, input logic [15:0] a, input logic [63:0] v);
        r_w[d] = 1'b1; addr[d] = a; din[d] = v;
        @(posedge clk); #1;
        r_w[d] = 1'b0; addr[d] = '0; din[d] = '0;
    endtask

    task automatic rd(input int d, input logic [15:0] a, output logic [63:0] v);
        r_w[d] = 1'b0; addr[d] = a;
        @(negedge clk);
        v = dout[d];
        @(posedge clk); #1;
        addr[d] = '0;
    endtask

    task automatic do_wr(input int d, input int cmd, input int w, input logic [63:0] v);
        wr(d, mk(cmd, w), v);
        model_write(d, cmd, w, v);
    endtask

    task automatic do_start(input int d, output int cycles);
        wr(d, mk(4, 0), '0);
        cycles = 0;
        while (busy[d] && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        model_compute(d);
        mdone[d] = 1'b1;
    endtask

    task automatic cmp_c(input int d, input string nm);
        logic [63:0] got;
        for (int w = 0; w < dimof(d) * dimof(d) / 4; w++) begin
            rd(d, mk(3, w), got);
            check($sformatf("%s w%0d", nm, w), got, model_read(d, 3, w));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rw;
        int          cmd;
        int          w;
        logic [63:0] data;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vt[$];

    function automatic void add_vec(input logic rw, input int cmd, input int w,
                                    input logic [63:0] data, input logic [63:0] exp, input string nm);
        vec_t v;
        v.rw = rw; v.cmd = cmd; v.w = w; v.data = data; v.exp = exp; v.name = nm;
        vt.push_back(v);
    endfunction

    task automatic apply_table(input int d);
        logic [63:0] got;
        foreach (vt[i]) begin
            if (vt[i].rw) do_wr(d, vt[i].cmd, vt[i].w, vt[i].data);
            else begin
                rd(d, mk(vt[i].cmd, vt[i].w), got);
                check(vt[i].name, got, vt[i].exp);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int          cyc, c0, op, cmd, w;
        logic [63:0] got, v, p0, p1, p1b;

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; r_w[d] = 1'b0; addr[d] = '0; din[d] = '0;
            model_reset(d);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        check("reset busy", 64'(busy[0]), 64'd0);
        check("reset done", 64'(done[0]), 64'd0);

        // Reset reads, then identity A and diag(2) B (WA=1 at DIM=8).
        add_vec(0, 5, 0, 0, 64'h0, "reset status");
        add_vec(0, 3, 0, 0, 64'h0, "reset c w0");
        add_vec(0, 3, 15, 0, 64'h0, "reset c w15");
        add_vec(0, 0, 0, 0, 64'h0, "reset cmd0");
        add_vec(0, 6, 3, 0, 64'h0, "reset cmd6");
        add_vec(0, 1, 2, 0, 64'h0, "a region read");
        for (int r = 0; r < 8; r++) add_vec(1, 1, r, 64'd1 << (8*r), 0, "");
        for (int r = 0; r < 8; r++) add_vec(1, 2, r, 64'd2 << (8*r), 0, "");
        apply_table(0);

        do_start(0, cyc);
        check("identity window", 64'(cyc), 64'd23);
        check("identity done port", 64'(done[0]), 64'd1);
        vt.delete();
        add_vec(0, 5, 0, 0, 64'h2, "identity status");
        for (int r = 0; r < 8; r++)
            for (int ch = 0; ch < 2; ch++)
                add_vec(0, 3, r*2 + ch, 0,
                        (ch == r/4) ? (64'd2 << (16*(r % 4))) : 64'd0,
                        $sformatf("identity c r%0d ch%0d", r, ch));
        apply_table(0);

        // C read-modify-write.
        do_wr(0, 3, 11, 64'h0004_0003_0002_0001);
        rd(0, mk(3, 10), got); check("rmw r5 ch0", got, 64'h0);
        rd(0, mk(3, 11), got); check("rmw r5 ch1", got, 64'h0004_0003_0002_0001);
        do_wr(0, 3, 12, 64'h1111_2222_3333_4444);
        rd(0, mk(3, 12), got); check("rmw r6 ch0", got, 64'h1111_2222_3333_4444);
        rd(0, mk(3, 13), got); check("rmw r6 ch1", got, 64'h0000_0002_0000_0000);

        // Done handling: explicit clear.
        do_wr(0, 5, 0, 64'h2);
        rd(0, mk(5, 0), got); check("status clear", got, 64'h0);

        // Clear presented on the completion edge: set wins.
        wr(0, mk(4, 0), '0);
        model_compute(0);
        repeat (22) @(posedge clk);
        #1;
        check("busy before last edge", 64'(busy[0]), 64'd1);
        wr(0, mk(5, 0), 64'h2);
        check("set beats clear busy", 64'(busy[0]), 64'd0);
        check("set beats clear done", 64'(done[0]), 64'd1);
        rd(0, mk(5, 0), got); check("set beats clear status", got, 64'h2);

        // New start clears done; start on the final RUN cycle is dropped.
        wr(0, mk(4, 0), '0);
        model_compute(0);
        check("start clears done", 64'(done[0]), 64'd0);
        check("start sets busy", 64'(busy[0]), 64'd1);
        repeat (22) @(posedge clk);
        #1;
        wr(0, mk(4, 0), '0);
        repeat (2) @(posedge clk);
        #1;
        check("late start dropped", 64'(busy[0]), 64'd0);
        rd(0, mk(5, 0), got); check("late start status", got, 64'h2);
        mdone[0] = 1'b1;

        // Busy lockout: A write, C write and second start inside the window.
        wr(0, mk(4, 0), '0);
        model_compute(0);
        wr(0, mk(1, 0), 64'h7F7F_7F7F_7F7F_7F7F);
        wr(0, mk(3, 0), 64'hDEAD_BEEF_0BAD_F00D);
        wr(0, mk(4, 0), '0);
        cyc = 3;
        while (busy[0] && cyc < 200) begin @(posedge clk); #1; cyc++; end
        check("lockout window", 64'(cyc), 64'd23);
        mdone[0] = 1'b1;
        cmp_c(0, "lockout c");

        // Randomized operations against the model.
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 9);
            v  = {$urandom, $urandom};
            case (op)
                0, 1, 2: do_wr(0, 1, $urandom_range(0, 11), v);
                3, 4:    do_wr(0, 2, $urandom_range(0, 11), v);
                5:       do_wr(0, 3, $urandom_range(0, 19), v);
                6, 7: begin
                    cmd = $urandom_range(0, 15);
                    w   = $urandom_range(0, 31);
                    rd(0, mk(cmd, w), got);
                    check($sformatf("rand read cmd%0d w%0d", cmd, w), got, model_read(0, cmd, w));
                end
                8: begin
                    do_start(0, cyc);
                    check("rand window", 64'(cyc), 64'd23);
                end
                default: do_wr(0, 5, 0, v);
            endcase
        end
        do_start(0, cyc);
        check("rand final window", 64'(cyc), 64'd23);
        cmp_c(0, "rand c");
        rd(0, mk(5, 0), got); check("rand status", got, 64'h2);

        // Reset mid-RUN at counter 10.
        wr(0, mk(4, 0), '0);
        repeat (10) @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check("midrun reset busy", 64'(busy[0]), 64'd0);
        check("midrun reset done", 64'(done[0]), 64'd0);
        rd(0, mk(5, 0), got); check("midrun reset status", got, 64'h0);
        rd(0, mk(3, 5), got); check("midrun reset c", got, 64'h0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        model_reset(0);
        @(posedge clk); #1;
        do_start(0, cyc);
        check("post reset window", 64'(cyc), 64'd23);
        rd(0, mk(5, 0), got); check("post reset status", got, 64'h2);

        // DIM=16 staging (WA=2, WC=4): B = identity, then A rows 3 and 4.
        for (int r = 0; r < 16; r++) begin
            do_wr(1, 2, r*2,     (r < 8)  ? (64'd1 << (8*r))     : 64'd0);
            do_wr(1, 2, r*2 + 1, (r >= 8) ? (64'd1 << (8*(r-8))) : 64'd0);
        end
        p0  = {$urandom, $urandom};
        p1  = {$urandom, $urandom};
        p1b = {$urandom, $urandom};
        c0 = wren_a16;
        do_wr(1, 1, 6, p0);
        check("wren after part0", 64'(wren_a16 - c0), 64'd0);
        do_wr(1, 1, 7, p1);
        check("wren after row3 part1", 64'(wren_a16 - c0), 64'd1);
        do_wr(1, 1, 9, p1b);
        check("wren after row4 part1", 64'(wren_a16 - c0), 64'd2);
        do_start(1, cyc);
        check("dim16 window", 64'(cyc), 64'd47);
        rd(1, mk(3, 12), got); check("row3 ch0", got, lanes(p0, 0));
        rd(1, mk(3, 15), got); check("row3 ch3", got, lanes(p1, 4));
        rd(1, mk(3, 16), got); check("row4 ch0 stale", got, lanes(p0, 0));
        rd(1, mk(3, 17), got); check("row4 ch1 stale", got, lanes(p0, 4));
        rd(1, mk(3, 18), got); check("row4 ch2 new", got, lanes(p1b, 0));
        rd(1, mk(3, 19), got); check("row4 ch3 new", got, lanes(p1b, 4));
        cmp_c(1, "dim16 c");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
